// File: rtl/div_sched_ctrl.sv
// Sequences the iterative divider for EX: latches operands, holds div_start, stalls until ready, writes HI/LO.
// Optional DIV_ZERO_BYPASS_EN skips the divider for zero divisors (no HI/LO write, 1-cycle stall).
module div_sched_ctrl #(
    parameter int TIMEOUT_CYC = 48,
    parameter int CNT_W       = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ex_hold,
    input  logic        op_valid,
    input  logic        op_signed,
    input  logic [31:0] opr1,
    input  logic [31:0] opr2,
    input  logic        div_ready,
    input  logic [63:0] div_res,
    output logic        div_start,
    output logic        div_abandon,
    output logic        div_signed,
    output logic [31:0] div_opr1,
    output logic [31:0] div_opr2,
    output logic        stall_req,
    output logic        hilo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic               start_q, start_d;
    logic               abandon_q, abandon_d;
    logic               sgn_q, sgn_d;
    logic [31:0]        opr1_q, opr1_d;
    logic [31:0]        opr2_q, opr2_d;
    logic               we_q, we_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               terr_q, terr_d;
    logic               zero_bypass;

`ifdef DIV_ZERO_BYPASS_EN
    assign zero_bypass = (opr2 == 32'd0);
`else
    assign zero_bypass = 1'b0;
`endif

    // A flush in the issue cycle must not stall the flushed instruction.
    assign stall_req = (state_q == BUSY) || ((state_q == IDLE) && op_valid && !flush);

    always_comb begin
        state_d   = state_q;
        start_d   = start_q;
        abandon_d = 1'b0;
        sgn_d     = sgn_q;
        opr1_d    = opr1_q;
        opr2_d    = opr2_q;
        we_d      = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        terr_d    = terr_q;

        if (flush) begin
            state_d   = IDLE;
            start_d   = 1'b0;
            abandon_d = 1'b1;
            cnt_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (op_valid) begin
                        terr_d = 1'b0;
                        cnt_d  = '0;
                        if (zero_bypass) begin
                            state_d = DONE;
                        end else begin
                            opr1_d  = opr1;
                            opr2_d  = opr2;
                            sgn_d   = op_signed;
                            start_d = 1'b1;
                            state_d = BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (div_ready) begin
                        hi_d    = div_res[63:32];
                        lo_d    = div_res[31:0];
                        we_d    = 1'b1;
                        start_d = 1'b0;
                        state_d = DONE;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        abandon_d = 1'b1;
                        terr_d    = 1'b1;
                        start_d   = 1'b0;
                        state_d   = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    // The finished instruction may linger in EX; it must not reissue.
                    start_d = 1'b0;
                    if (!ex_hold) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    start_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            start_q   <= 1'b0;
            abandon_q <= 1'b0;
            sgn_q     <= 1'b0;
            opr1_q    <= '0;
            opr2_q    <= '0;
            we_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            abandon_q <= abandon_d;
            sgn_q     <= sgn_d;
            opr1_q    <= opr1_d;
            opr2_q    <= opr2_d;
            we_q      <= we_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            terr_q    <= terr_d;
        end
    end

    assign div_start   = start_q;
    assign div_abandon = abandon_q;
    assign div_signed  = sgn_q;
    assign div_opr1    = opr1_q;
    assign div_opr2    = opr2_q;
    assign hilo_we     = we_q;
    assign hi_wdata    = hi_q;
    assign lo_wdata    = lo_q;
    assign timeout_err = terr_q;

endmodule
